// File: rtl/shader_pkg.sv
// rtl/shader_pkg.sv - shared types and frame-memory geometry for the shader scheduler
package shader_pkg;

    localparam int FB_DW   = 256;
    localparam int FB_AW   = 7;
    localparam int FB_ROWS = 96;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_DONE
    } state_e;

    // Rows at or above FB_ROWS exist in the BRAM but are not part of the visible frame.
    function automatic logic row_in_frame(input logic [FB_AW-1:0] row);
        return int'(row) < FB_ROWS;
    endfunction

endpackage

// File: rtl/fb_port_mux.sv
// rtl/fb_port_mux.sv - N-way frame-memory port mux selected by owner index
// Ports:
//   owner_i/valid_i   selected shader and whether any shader owns the port
//   we_i, w_addr_i, r_addr_i, w_dout_i   packed per-shader memory requests
//   we_o, w_addr_o, r_addr_o, w_dout_o   request of the owner, or all zero
module fb_port_mux #(
    parameter int N  = 4,
    parameter int DW = 256,
    parameter int AW = 7,
    parameter int IW = 3
) (
    input  logic [IW-1:0]   owner_i,
    input  logic            valid_i,
    input  logic [N-1:0]    we_i,
    input  logic [N*AW-1:0] w_addr_i,
    input  logic [N*AW-1:0] r_addr_i,
    input  logic [N*DW-1:0] w_dout_i,
    output logic            we_o,
    output logic [AW-1:0]   w_addr_o,
    output logic [AW-1:0]   r_addr_o,
    output logic [DW-1:0]   w_dout_o
);

    always_comb begin
        we_o     = 1'b0;
        w_addr_o = '0;
        r_addr_o = '0;
        w_dout_o = '0;
        if (valid_i) begin
            for (int i = 0; i < N; i++) begin
                if (owner_i == IW'(i)) begin
                    we_o     = we_i[i];
                    w_addr_o = w_addr_i[i*AW +: AW];
                    r_addr_o = r_addr_i[i*AW +: AW];
                    w_dout_o = w_dout_i[i*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/shader_scheduler.sv
// rtl/shader_scheduler.sv - per-frame sequencer and memory arbiter for frame-memory shaders
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_tick, pass_en   frame start pulse and per-shader enable mask
//   sh_start, sh_ready    one-hot launch pulse and per-shader idle flag
//   sh_we/sh_w_addr/sh_r_addr/sh_w_dout   packed shader memory requests
//   sh_r_dout             read data broadcast to every shader
//   mem_*                 single frame-memory port, driven by the active shader only
//   busy, cur_idx         sequence in progress, currently selected shader
//   frame_done, overrun, timeout   one-cycle status pulses
module shader_scheduler
    import shader_pkg::*;
#(
    parameter int NUM_SH  = 4,
    parameter int DW      = FB_DW,
    parameter int AW      = FB_AW,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [NUM_SH-1:0]  pass_en,
    output logic [NUM_SH-1:0]  sh_start,
    input  logic [NUM_SH-1:0]  sh_ready,
    input  logic [NUM_SH-1:0]  sh_we,
    input  logic [NUM_SH*AW-1:0] sh_w_addr,
    input  logic [NUM_SH*AW-1:0] sh_r_addr,
    input  logic [NUM_SH*DW-1:0] sh_w_dout,
    output logic [DW-1:0]      sh_r_dout,
    output logic               mem_we,
    output logic [AW-1:0]      mem_w_addr,
    output logic [AW-1:0]      mem_r_addr,
    output logic [DW-1:0]      mem_w_dout,
    input  logic [DW-1:0]      mem_r_dout,
    output logic               busy,
    output logic [2:0]         cur_idx,
    output logic               frame_done,
    output logic               overrun,
    output logic               timeout
);

    localparam int         WDW      = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_SH - 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT - 1);

    state_e            state_q;
    logic [2:0]        idx_q;
    logic [NUM_SH-1:0] pending_q;
    logic [NUM_SH-1:0] sh_start_q;
    logic [WDW-1:0]    wdog_q;
    logic              frame_done_q;
    logic              overrun_q;
    logic              timeout_q;

    logic [NUM_SH-1:0] idx_oh;
    logic              cur_pending;
    logic              cur_ready;
    logic              own_valid;
    logic              pass_finished;

    // One-hot decode avoids indexing narrow vectors with the 3-bit index.
    assign idx_oh      = NUM_SH'(1) << idx_q;
    assign cur_pending = |(pending_q & idx_oh);
    assign cur_ready   = |(sh_ready & idx_oh);
    assign own_valid   = (state_q == S_LAUNCH) || (state_q == S_WAIT_BUSY) ||
                         (state_q == S_WAIT_DONE);
    assign pass_finished = (state_q == S_WAIT_DONE) && cur_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pending_q    <= '0;
            sh_start_q   <= '0;
            wdog_q       <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            sh_start_q   <= '0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            // A tick while the sequence runs (including DONE) is reported and dropped.
            overrun_q    <= frame_tick && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (frame_tick) begin
                        pending_q <= pass_en;
                        idx_q     <= '0;
                        state_q   <= (pass_en == '0) ? S_DONE : S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (cur_pending) begin
                        sh_start_q <= idx_oh;
                        state_q    <= S_LAUNCH;
                    end else if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                S_LAUNCH: begin
                    wdog_q  <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    if (pass_finished || (wdog_q == WD_LIMIT)) begin
                        // Completion and abandonment advance identically.
                        timeout_q <= !pass_finished;
                        pending_q <= pending_q & ~idx_oh;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= S_SELECT;
                        end
                    end else begin
                        wdog_q <= wdog_q + WDW'(1);
                        if ((state_q == S_WAIT_BUSY) && !cur_ready) begin
                            state_q <= S_WAIT_DONE;
                        end
                    end
                end
                S_DONE: begin
                    frame_done_q <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    fb_port_mux #(
        .N  (NUM_SH),
        .DW (DW),
        .AW (AW),
        .IW (3)
    ) u_fb_port_mux (
        .owner_i  (idx_q),
        .valid_i  (own_valid),
        .we_i     (sh_we),
        .w_addr_i (sh_w_addr),
        .r_addr_i (sh_r_addr),
        .w_dout_i (sh_w_dout),
        .we_o     (mem_we),
        .w_addr_o (mem_w_addr),
        .r_addr_o (mem_r_addr),
        .w_dout_o (mem_w_dout)
    );

    assign sh_start   = sh_start_q;
    assign sh_r_dout  = mem_r_dout;
    assign busy       = (state_q != S_IDLE);
    assign cur_idx    = idx_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_shader_scheduler.sv
// tb/tb_shader_scheduler.sv - self-checking bench for shader_scheduler
module tb_shader_scheduler;

    localparam int N    = 4;
    localparam int DW   = 256;
    localparam int AW   = 7;
    localparam int BUSY = 290;

    logic            clk;
    logic            rst_n;
    logic            frame_tick;
    logic [N-1:0]    pass_en;
    logic [N-1:0]    sh_start;
    logic [N-1:0]    sh_ready;
    logic [N-1:0]    sh_we;
    logic [N*AW-1:0] sh_w_addr;
    logic [N*AW-1:0] sh_r_addr;
    logic [N*DW-1:0] sh_w_dout;
    logic [DW-1:0]   sh_r_dout;
    logic            mem_we;
    logic [AW-1:0]   mem_w_addr;
    logic [AW-1:0]   mem_r_addr;
    logic [DW-1:0]   mem_w_dout;
    logic [DW-1:0]   mem_r_dout;
    logic            busy;
    logic [2:0]      cur_idx;
    logic            frame_done;
    logic            overrun;
    logic            timeout;

    shader_scheduler #(.NUM_SH(N), .DW(DW), .AW(AW), .TIMEOUT(1024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .pass_en    (pass_en),
        .sh_start   (sh_start),
        .sh_ready   (sh_ready),
        .sh_we      (sh_we),
        .sh_w_addr  (sh_w_addr),
        .sh_r_addr  (sh_r_addr),
        .sh_w_dout  (sh_w_dout),
        .sh_r_dout  (sh_r_dout),
        .mem_we     (mem_we),
        .mem_w_addr (mem_w_addr),
        .mem_r_addr (mem_r_addr),
        .mem_w_dout (mem_w_dout),
        .mem_r_dout (mem_r_dout),
        .busy       (busy),
        .cur_idx    (cur_idx),
        .frame_done (frame_done),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int lat;
    } exp_t;

    exp_t     sb[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       owner = -1;
    int       ref_cyc = 0;
    int       start_count = 0;
    int       done_count = 0;
    int       timeout_count = 0;
    int       overrun_count = 0;
    int       last_start_cyc = 0;
    int       last_done_cyc = 0;
    int       last_timeout_cyc = 0;
    int       cnt[N];
    logic [N-1:0] hang;

    function automatic logic [AW-1:0] wa(input int i);
        return AW'(i * 8 + 1);
    endfunction

    function automatic logic [AW-1:0] ra(input int i);
        return AW'(i * 8 + 5);
    endfunction

    function automatic logic [DW-1:0] wd(input int i);
        return {8{32'hC0DE_0000 + 32'(i)}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected launch order and latency for one frame: 2 cycles from the reference
    // event plus one per disabled shader skipped over.
    task automatic push_frame(input logic [N-1:0] en);
        int prev;
        exp_t e;
        prev = -1;
        for (int i = 0; i < N; i++) begin
            if (en[i]) begin
                e.idx = i;
                e.lat = 2 + (i - prev - 1);
                sb.push_back(e);
                prev = i;
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic ok;
        if (timeout === 1'b1) begin
            timeout_count++;
            last_timeout_cyc = cyc;
            owner   = -1;
            ref_cyc = cyc - 1;
        end
        if (overrun === 1'b1) overrun_count++;
        if (frame_done === 1'b1) begin
            done_count++;
            last_done_cyc = cyc;
            owner = -1;
        end
        if (sh_start !== '0) begin
            start_count++;
            last_start_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_start", DW'(sh_start), '0);
            end else begin
                e = sb.pop_front();
                chk("start_idx", DW'(sh_start), DW'(1) << e.idx);
                chk("start_latency", DW'(cyc - ref_cyc), DW'(e.lat));
                chk("start_prev_idle", DW'(sh_ready | hang), DW'(4'hF));
                chk("launch_owns_mem", DW'(mem_we), DW'(1));
                owner = e.idx;
            end
        end
        ok = (mem_we === 1'b0) ||
             ((owner >= 0) && (mem_w_addr === wa(owner)) &&
              (mem_r_addr === ra(owner)) && (mem_w_dout === wd(owner)));
        chk("mem_owner", DW'(ok), DW'(1));
    endtask

    // Shader models: go busy when started, come back ready BUSY cycles later unless hung.
    task automatic model();
        for (int i = 0; i < N; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0 && !hang[i]) begin
                    sh_ready[i] = 1'b1;
                    if (i == owner) ref_cyc = cyc;
                end
            end
            if (sh_start[i] === 1'b1) begin
                sh_ready[i] = 1'b0;
                cnt[i] = BUSY;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        model();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        ref_cyc = cyc;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic wait_start(input int bound);
        int s;
        int n;
        s = start_count;
        n = 0;
        while (start_count == s && n < bound) begin
            step();
            n++;
        end
        chk("wait_start_bound", DW'(start_count != s), DW'(1));
    endtask

    task automatic wait_done(input int bound);
        int s;
        int n;
        s = done_count;
        n = 0;
        while (done_count == s && n < bound) begin
            step();
            n++;
        end
        chk("wait_done_bound", DW'(done_count != s), DW'(1));
    endtask

    initial begin
        int s0;
        int d0;
        int k;
        int t;
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        pass_en    = '0;
        sh_ready   = '1;
        sh_we      = '1;
        hang       = '0;
        mem_r_dout = {8{32'h1234_5678}};
        for (int i = 0; i < N; i++) begin
            cnt[i] = 0;
            sh_w_addr[i*AW +: AW] = wa(i);
            sh_r_addr[i*AW +: AW] = ra(i);
            sh_w_dout[i*DW +: DW] = wd(i);
        end

        // Reset with every shader (shader 2 included) requesting writes.
        step();
        step();
        chk("rst_mem_we", DW'(mem_we), '0);
        chk("rst_mem_w_addr", DW'(mem_w_addr), '0);
        chk("rst_busy", DW'(busy), '0);
        chk("rst_sh_start", DW'(sh_start), '0);
        chk("rst_cur_idx", DW'(cur_idx), '0);
        chk("rst_pulses", DW'({frame_done, overrun, timeout}), '0);
        rst_n = 1'b1;
        step();
        step();
        chk("post_rst_mem_we", DW'(mem_we), '0);
        chk("post_rst_busy", DW'(busy), '0);
        chk("r_dout_broadcast", sh_r_dout, {8{32'h1234_5678}});

        // Shaders 0, 1, 3; mid-frame pass_en change must not matter.
        pass_en = 4'b1011;
        push_frame(4'b1011);
        s0 = start_count;
        d0 = done_count;
        tick();
        chk("busy_after_tick", DW'(busy), DW'(1));
        pass_en = 4'b0100;
        wait_done(2000);
        chk("frame1_starts", DW'(start_count - s0), DW'(3));
        chk("frame1_done", DW'(done_count - d0), DW'(1));
        chk("frame1_sb_empty", DW'(sb.size()), '0);
        step();
        chk("frame1_idle", DW'(busy), '0);

        // Empty mask: frame_done two cycles after the tick; a tick during DONE is an overrun.
        pass_en = 4'b0000;
        s0 = start_count;
        d0 = done_count;
        k = cyc;
        tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("empty_done_cycle", DW'(last_done_cyc), DW'(k + 2));
        chk("done_tick_overrun", DW'(overrun), DW'(1));
        for (int i = 0; i < 5; i++) step();
        chk("empty_single_done", DW'(done_count - d0), DW'(1));
        chk("empty_no_start", DW'(start_count - s0), '0);
        chk("empty_idle", DW'(busy), '0);

        // Shader 1 hangs: abandoned by the watchdog, shader 2 goes next.
        hang[1] = 1'b1;
        pass_en = 4'b0110;
        push_frame(4'b0110);
        d0 = timeout_count;
        tick();
        wait_start(20);
        t = last_start_cyc;
        wait_done(3000);
        chk("timeout_count", DW'(timeout_count - d0), DW'(1));
        chk("timeout_cycle", DW'(last_timeout_cyc - t), DW'(1025));
        chk("timeout_sb_empty", DW'(sb.size()), '0);
        hang[1]     = 1'b0;
        sh_ready[1] = 1'b1;
        step();

        // Overrun 50 cycles into a pass.
        pass_en = 4'b0001;
        push_frame(4'b0001);
        d0 = done_count;
        s0 = overrun_count;
        tick();
        wait_start(20);
        for (int i = 0; i < 50; i++) step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("overrun_pulse", DW'(overrun), DW'(1));
        step();
        chk("overrun_one_cycle", DW'(overrun), '0);
        wait_done(1000);
        for (int i = 0; i < 5; i++) step();
        chk("overrun_single_done", DW'(done_count - d0), DW'(1));
        chk("overrun_count", DW'(overrun_count - s0), DW'(1));
        chk("overrun_idle", DW'(busy), '0);

        // Reset during WAIT_DONE of shader 0.
        pass_en = 4'b0001;
        push_frame(4'b0001);
        tick();
        wait_start(20);
        for (int i = 0; i < 20; i++) step();
        chk("pre_rst_busy", DW'(busy), DW'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", DW'(busy), '0);
        chk("async_rst_mem_we", DW'(mem_we), '0);
        chk("async_rst_mem_data", DW'({mem_w_addr, mem_r_addr}) | mem_w_dout, '0);
        chk("async_rst_start_idx", DW'({sh_start, cur_idx}), '0);
        chk("async_rst_pulses", DW'({frame_done, overrun, timeout}), '0);
        owner = -1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        sh_ready = '1;
        step();
        rst_n = 1'b1;
        s0 = start_count;
        for (int i = 0; i < 20; i++) step();
        chk("post_rst_no_start", DW'(start_count - s0), '0);
        chk("post_rst_idle", DW'(busy), '0);

        // Only the last shader enabled: three skipped indices.
        pass_en = 4'b1000;
        push_frame(4'b1000);
        tick();
        wait_done(1000);
        chk("last_only_start", DW'(start_count - s0), DW'(1));
        chk("final_sb_empty", DW'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
